// File: rtl/litepcie_rc_pkg.sv
// Shared constants for the RC completion adapter: fmt/type codes, descriptor field
// offsets, tuser output bit indices and the expected-beat helper.
package litepcie_rc_pkg;

   localparam logic [7:0] CPL    = 8'h0A;
   localparam logic [7:0] CPLD   = 8'h4A;
   localparam logic [7:0] CPLLK  = 8'h0B;
   localparam logic [7:0] CPLDLK = 8'h4B;

   localparam int unsigned DESC_LOWADDR_LSB = 0;
   localparam int unsigned DESC_BYTECNT_LSB = 16;
   localparam int unsigned DESC_LOCKED_BIT  = 29;
   localparam int unsigned DESC_DWLEN_LSB   = 32;
   localparam int unsigned DESC_STATUS_LSB  = 43;
   localparam int unsigned DESC_POISON_BIT  = 46;
   localparam int unsigned DESC_REQID_LSB   = 48;
   localparam int unsigned DESC_TAG_LSB     = 64;
   localparam int unsigned DESC_CPLID_LSB   = 72;
   localparam int unsigned DESC_TC_LSB      = 89;
   localparam int unsigned DESC_ATTR_LSB    = 92;

   localparam int unsigned TUSER_DISC   = 0;
   localparam int unsigned TUSER_POISON = 1;
   localparam int unsigned TUSER_LENERR = 2;
   localparam int unsigned TUSER_WIDTH  = 85;

   // Beats for a completion: 3 header DW plus D payload DW, D=0 encodes 1024.
   function automatic logic [8:0] rc_exp_beats(input logic [9:0] dwlen,
                                                input int unsigned shift);
      logic [10:0] w_d;
      logic [11:0] w_sum;
      w_d   = (dwlen == 10'd0) ? 11'd1024 : {1'b0, dwlen};
      w_sum = {1'b0, w_d} + 12'd3 + ((12'd1 << shift) - 12'd1);
      return 9'(w_sum >> shift);
   endfunction

endpackage

// File: rtl/rc_skid_buffer.sv
// Two-entry valid/ready buffer (main + skid register); input ready comes straight from
// the skid-occupied flop, so it never depends combinationally on the output ready.
module rc_skid_buffer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
);

   logic             r_main_v;
   logic             r_skid_v;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_main_v <= 1'b0;
         r_skid_v <= 1'b0;
         r_main   <= '0;
         r_skid   <= '0;
      end else if (r_skid_v) begin
         if (i_ready) begin
            r_main   <= r_skid;
            r_skid_v <= 1'b0;
         end
      end else if (!r_main_v || i_ready) begin
         // Main free or draining this cycle: the new beat bypasses the skid.
         r_main_v <= i_valid;
         if (i_valid) begin
            r_main <= i_data;
         end
      end else if (i_valid) begin
         r_skid   <= i_data;
         r_skid_v <= 1'b1;
      end
   end

   assign o_ready = !r_skid_v;
   assign o_valid = r_main_v;
   assign o_data  = r_main;

endmodule

// File: rtl/m_axis_rc_adapt_pipe.sv
// RC descriptor-format completion to legacy 3DW TLP adapter with length checking and
// sticky error flags. Optional error counter enabled by LITEPCIE_RC_ERR_CNT_EN.
module m_axis_rc_adapt_pipe
   import litepcie_rc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned DISC_BIT   = 42
) (
   input  logic                   user_clk,
   input  logic                   user_reset_n,
   input  logic [DATA_WIDTH-1:0]  m_axis_rc_tdata_a,
   input  logic [KEEP_WIDTH-1:0]  m_axis_rc_tkeep_a,
   input  logic                   m_axis_rc_tlast_a,
   input  logic [TUSER_WIDTH-1:0] m_axis_rc_tuser_a,
   input  logic                   m_axis_rc_tvalid_a,
   output logic [3:0]             m_axis_rc_tready_a,
   output logic [DATA_WIDTH-1:0]  m_axis_rc_tdata,
   output logic [KEEP_WIDTH-1:0]  m_axis_rc_tkeep,
   output logic                   m_axis_rc_tlast,
   output logic [TUSER_WIDTH-1:0] m_axis_rc_tuser,
   output logic                   m_axis_rc_tvalid,
`ifdef LITEPCIE_RC_ERR_CNT_EN
   output logic [15:0]            rc_err_count,
`endif
   input  logic [3:0]             m_axis_rc_tready
);

   localparam int unsigned SHIFT = $clog2(DATA_WIDTH / 32);
   localparam int unsigned PW    = DATA_WIDTH + KEEP_WIDTH + 4;

   logic [8:0] r_beat;
   logic [8:0] r_exp;
   logic       r_poison;
   logic       r_disc;

   logic                  w_ready;
   logic                  w_accept;
   logic                  w_sop;
   logic [9:0]            w_dwlen;
   logic [11:0]           w_bytecnt;
   logic [7:0]            w_fmt;
   logic [127:0]          w_hdr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [KEEP_WIDTH-1:0] w_keep;
   logic [8:0]            w_exp_now;
   logic [8:0]            w_exp;
   logic                  w_poison;
   logic                  w_disc;
   logic                  w_lenerr;
   logic [2:0]            w_user;
   logic [PW-1:0]         w_in_pl;
   logic [PW-1:0]         w_out_pl;
   logic                  w_out_valid;
   logic                  w_unused_ok;

   assign w_accept  = m_axis_rc_tvalid_a && w_ready;
   assign w_sop     = (r_beat == 9'd0);
   assign w_dwlen   = m_axis_rc_tdata_a[DESC_DWLEN_LSB +: 10];
   assign w_bytecnt = m_axis_rc_tdata_a[DESC_BYTECNT_LSB +: 12];

   always_comb begin
      w_fmt = CPL;
      if (w_bytecnt != 12'd0) begin
         w_fmt = m_axis_rc_tdata_a[DESC_LOCKED_BIT] ? CPLDLK : CPLD;
      end else if (m_axis_rc_tdata_a[DESC_LOCKED_BIT]) begin
         w_fmt = CPLLK;
      end
   end

   // {DW3, DW2, DW1, DW0}, little-endian dwords; DW3 is the first payload dword.
   assign w_hdr = {m_axis_rc_tdata_a[127:96],
                   m_axis_rc_tdata_a[DESC_REQID_LSB +: 16], m_axis_rc_tdata_a[DESC_TAG_LSB +: 8],
                   1'b0, m_axis_rc_tdata_a[DESC_LOWADDR_LSB +: 7],
                   m_axis_rc_tdata_a[DESC_CPLID_LSB +: 16], m_axis_rc_tdata_a[DESC_STATUS_LSB +: 3],
                   1'b0, w_bytecnt,
                   w_fmt, 1'b0, m_axis_rc_tdata_a[DESC_TC_LSB +: 3], 4'b0000, 1'b0, 1'b0,
                   m_axis_rc_tdata_a[DESC_ATTR_LSB +: 2], 2'b00, w_dwlen};

   always_comb begin
      w_data = m_axis_rc_tdata_a;
      w_keep = m_axis_rc_tuser_a[KEEP_WIDTH-1:0];
      if (w_sop) begin
         w_data[127:0] = w_hdr;
         w_keep[11:0]  = 12'hFFF;
      end
   end

   assign w_exp_now = rc_exp_beats(w_dwlen, SHIFT);
   assign w_exp     = w_sop ? w_exp_now : r_exp;
   assign w_poison  = w_sop ? m_axis_rc_tdata_a[DESC_POISON_BIT] : r_poison;
   assign w_disc    = r_disc | m_axis_rc_tuser_a[DISC_BIT];
   // Widened compare so a saturated counter (511 + 1) never matches a 9-bit expectation.
   assign w_lenerr  = m_axis_rc_tlast_a && (({1'b0, r_beat} + 10'd1) != {1'b0, w_exp});

   always_comb begin
      w_user               = 3'b000;
      w_user[TUSER_DISC]   = w_disc;
      w_user[TUSER_POISON] = w_poison;
      w_user[TUSER_LENERR] = w_lenerr;
   end

   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         r_beat   <= 9'd0;
         r_exp    <= 9'd0;
         r_poison <= 1'b0;
         r_disc   <= 1'b0;
      end else if (w_accept) begin
         if (m_axis_rc_tlast_a) begin
            r_beat <= 9'd0;
         end else if (r_beat != 9'h1FF) begin
            r_beat <= r_beat + 9'd1;
         end
         r_disc <= m_axis_rc_tlast_a ? 1'b0 : w_disc;
         if (w_sop) begin
            r_poison <= m_axis_rc_tdata_a[DESC_POISON_BIT];
            r_exp    <= w_exp_now;
         end
      end
   end

   assign w_in_pl = {w_user, m_axis_rc_tlast_a, w_keep, w_data};

   rc_skid_buffer #(
      .WIDTH(PW)
   ) u_skid (
      .i_clk   (user_clk),
      .i_rst_n (user_reset_n),
      .i_valid (m_axis_rc_tvalid_a),
      .o_ready (w_ready),
      .i_data  (w_in_pl),
      .o_valid (w_out_valid),
      .i_ready (m_axis_rc_tready[0]),
      .o_data  (w_out_pl)
   );

   assign m_axis_rc_tready_a = {4{w_ready}};
   assign m_axis_rc_tvalid   = w_out_valid;
   assign m_axis_rc_tdata    = w_out_pl[DATA_WIDTH-1:0];
   assign m_axis_rc_tkeep    = w_out_pl[DATA_WIDTH +: KEEP_WIDTH];
   assign m_axis_rc_tlast    = w_out_pl[DATA_WIDTH + KEEP_WIDTH];
   assign m_axis_rc_tuser    = {{(TUSER_WIDTH - 3){1'b0}}, w_out_pl[PW-1 -: 3]};

`ifdef LITEPCIE_RC_ERR_CNT_EN
   logic [15:0] r_err_count;

   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         r_err_count <= 16'd0;
      end else if (w_out_valid && m_axis_rc_tready[0] && m_axis_rc_tlast &&
                   (m_axis_rc_tuser[2:0] != 3'b000) && (r_err_count != 16'hFFFF)) begin
         r_err_count <= r_err_count + 16'd1;
      end
   end

   assign rc_err_count = r_err_count;
`endif

   assign w_unused_ok = ^{m_axis_rc_tkeep_a, m_axis_rc_tready[3:1], m_axis_rc_tuser_a};

endmodule

// File: tb/tb_m_axis_rc_adapt_pipe.sv
// Directed bench for m_axis_rc_adapt_pipe at 512/256/128-bit widths; one DUT is active at a
// time. Define LITEPCIE_RC_ERR_CNT_EN to also check the error counter.
module tb_m_axis_rc_adapt_pipe;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]   sel      = 2'd0;
   logic [511:0] in_data  = '0;
   logic [63:0]  in_be    = '0;
   logic         in_last  = 1'b0;
   logic         in_disc  = 1'b0;
   logic         in_valid = 1'b0;
   logic         rdy      = 1'b1;
   logic         tog      = 1'b0;

   int n_checks = 0;
   int n_errs   = 0;
   int acc_cnt  = 0;
   int out_cnt  = 0;

   typedef struct packed {
      logic [511:0] data;
      logic [63:0]  keep;
      logic         last;
      logic [84:0]  user;
   } beat_t;

   beat_t q[$];

   logic [84:0] tu512, tu256, tu128;
   assign tu512 = {4'b0, in_disc, 16'b0, in_be};
   assign tu256 = {42'b0, in_disc, 10'b0, in_be[31:0]};
   assign tu128 = {42'b0, in_disc, 26'b0, in_be[15:0]};

   logic v512, v256, v128;
   assign v512 = in_valid && (sel == 2'd0);
   assign v256 = in_valid && (sel == 2'd1);
   assign v128 = in_valid && (sel == 2'd2);

   logic [3:0]   ra512, ra256, ra128;
   logic [511:0] d512;
   logic [255:0] d256;
   logic [127:0] d128;
   logic [63:0]  k512;
   logic [31:0]  k256;
   logic [15:0]  k128;
   logic         l512, l256, l128, ov512, ov256, ov128;
   logic [84:0]  u512, u256, u128;
`ifdef LITEPCIE_RC_ERR_CNT_EN
   logic [15:0]  cnt512, cnt256, cnt128;
`endif

   m_axis_rc_adapt_pipe #(.DATA_WIDTH(512), .DISC_BIT(80)) u_dut512 (
      .user_clk(clk), .user_reset_n(rst_n),
      .m_axis_rc_tdata_a(in_data), .m_axis_rc_tkeep_a(in_be), .m_axis_rc_tlast_a(in_last),
      .m_axis_rc_tuser_a(tu512), .m_axis_rc_tvalid_a(v512), .m_axis_rc_tready_a(ra512),
      .m_axis_rc_tdata(d512), .m_axis_rc_tkeep(k512), .m_axis_rc_tlast(l512),
      .m_axis_rc_tuser(u512), .m_axis_rc_tvalid(ov512),
`ifdef LITEPCIE_RC_ERR_CNT_EN
      .rc_err_count(cnt512),
`endif
      .m_axis_rc_tready({3'b000, rdy})
   );

   m_axis_rc_adapt_pipe #(.DATA_WIDTH(256)) u_dut256 (
      .user_clk(clk), .user_reset_n(rst_n),
      .m_axis_rc_tdata_a(in_data[255:0]), .m_axis_rc_tkeep_a(in_be[31:0]),
      .m_axis_rc_tlast_a(in_last),
      .m_axis_rc_tuser_a(tu256), .m_axis_rc_tvalid_a(v256), .m_axis_rc_tready_a(ra256),
      .m_axis_rc_tdata(d256), .m_axis_rc_tkeep(k256), .m_axis_rc_tlast(l256),
      .m_axis_rc_tuser(u256), .m_axis_rc_tvalid(ov256),
`ifdef LITEPCIE_RC_ERR_CNT_EN
      .rc_err_count(cnt256),
`endif
      .m_axis_rc_tready({3'b000, rdy})
   );

   m_axis_rc_adapt_pipe #(.DATA_WIDTH(128)) u_dut128 (
      .user_clk(clk), .user_reset_n(rst_n),
      .m_axis_rc_tdata_a(in_data[127:0]), .m_axis_rc_tkeep_a(in_be[15:0]),
      .m_axis_rc_tlast_a(in_last),
      .m_axis_rc_tuser_a(tu128), .m_axis_rc_tvalid_a(v128), .m_axis_rc_tready_a(ra128),
      .m_axis_rc_tdata(d128), .m_axis_rc_tkeep(k128), .m_axis_rc_tlast(l128),
      .m_axis_rc_tuser(u128), .m_axis_rc_tvalid(ov128),
`ifdef LITEPCIE_RC_ERR_CNT_EN
      .rc_err_count(cnt128),
`endif
      .m_axis_rc_tready({3'b000, rdy})
   );

   beat_t      cur;
   logic       obs_valid;
   logic [3:0] obs_ready;

   always_comb begin
      case (sel)
         2'd0: begin
            cur = {d512, k512, l512, u512};
            obs_valid = ov512;
            obs_ready = ra512;
         end
         2'd1: begin
            cur = {256'b0, d256, 32'b0, k256, l256, u256};
            obs_valid = ov256;
            obs_ready = ra256;
         end
         default: begin
            cur = {384'b0, d128, 48'b0, k128, l128, u128};
            obs_valid = ov128;
            obs_ready = ra128;
         end
      endcase
   end

   always @(posedge clk) begin
      #1;
      rdy = tog ? ~rdy : 1'b1;
   end

   // Output monitor: collects transfers, checks ready-vs-occupancy and stall stability.
   logic  hold = 1'b0;
   beat_t held;
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         out_cnt = 0;
         hold    = 1'b0;
      end else begin
         n_checks++;
         assert (obs_ready === (((acc_cnt - out_cnt) < 2) ? 4'hF : 4'h0)) else begin
            n_errs++;
            $error("FAIL tready_a_vs_occupancy: observed %h expected %h (in flight %0d)",
                   obs_ready, (((acc_cnt - out_cnt) < 2) ? 4'hF : 4'h0), acc_cnt - out_cnt);
         end
         if (hold) begin
            n_checks++;
            assert (obs_valid && (cur === held)) else begin
               n_errs++;
               $error("FAIL stall_stable: observed valid=%b %h expected valid=1 %h",
                      obs_valid, cur, held);
            end
         end
         hold = obs_valid && !rdy;
         held = cur;
         if (obs_valid && rdy) begin
            q.push_back(cur);
            out_cnt++;
         end
      end
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [511:0] d, input logic [63:0] be, input logic last,
                       input logic disc);
      logic r;
      int   t;
      in_data  = d;
      in_be    = be;
      in_last  = last;
      in_disc  = disc;
      in_valid = 1'b1;
      r = 1'b0;
      t = 0;
      while (!r && t < 50) begin
         @(negedge clk);
         r = obs_ready[0];
         @(posedge clk);
         #1;
         t++;
      end
      in_valid = 1'b0;
      n_checks++;
      assert (r) else begin
         n_errs++;
         $error("FAIL send_accept: observed tready_a low for %0d cycles expected acceptance", t);
      end
      if (r) acc_cnt++;
   endtask

   task automatic expect_beat(input string tag, input logic [511:0] d, input logic [63:0] k,
                              input logic l, input logic [2:0] u);
      int t;
      t = 0;
      while (q.size() == 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      assert (q.size() != 0) else begin
         n_errs++;
         $error("FAIL %s_present: observed no beat expected one", tag);
      end
      if (q.size() != 0) begin
         beat_t b;
         b = q.pop_front();
         chk({tag, "_data"}, b.data, d);
         chk({tag, "_keep"}, 512'(b.keep), 512'(k));
         chk({tag, "_last"}, 512'(b.last), 512'(l));
         chk({tag, "_user"}, 512'(b.user), 512'(u));
      end
   endtask

   task automatic expect_empty(input string tag);
      repeat (4) @(negedge clk);
      chk(tag, 512'(q.size()), 512'd0);
      sync();
   endtask

   localparam logic [127:0] P1_IN  = 128'h12345678_00000033_00000001_00040000;
   localparam logic [127:0] P1_OUT = 128'h12345678_00003300_00000004_4A000001;

`ifdef LITEPCIE_RC_ERR_CNT_EN
   logic [15:0] cnt_before;
`endif

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      sync();

      // Reset state
      chk("rst_tvalid", 512'(ov512), 512'd0);
      chk("rst_tready_a", 512'(ra512), 512'hF);
      chk("rst_tdata", d512, 512'd0);
      chk("rst_tuser", 512'(u512), 512'd0);

      // 512-bit single-beat CplD, dwlen=4, bytecnt=16, tag=0x5A, lowaddr=0x10
      sel = 2'd0;
      send({{12{32'h12345678}}, 128'hDEADBEEF_0001005A_02000004_00100010},
           64'h0FFF_FFFF, 1'b1, 1'b0);
      expect_beat("cpld512",
                  {{12{32'h12345678}}, 128'hDEADBEEF_02005A10_01000010_4A000004},
                  64'h0FFF_FFFF, 1'b1, 3'b000);
      expect_empty("cpld512_count");

      // 512-bit locked, bytecnt=0, dwlen=0 (1024 DW) in one beat: CplLk + length error
      send(512'h2000_0000, 64'h0, 1'b1, 1'b0);
      expect_beat("cpllk512", 512'h0B00_0000, 64'hFFF, 1'b1, 3'b100);
      expect_empty("cpllk512_count");
`ifdef LITEPCIE_RC_ERR_CNT_EN
      chk("errcnt512", 512'(cnt512), 512'd1);
`endif

      // 256-bit dwlen=14 (3 beats expected) ended after 2 beats
      sel = 2'd1;
      send({256'h0, 128'hCAFEBABE_00000000_11111111_22222222,
            128'h33330000_00000000_0000000E_00380000}, 64'hFFFF_FFFF, 1'b0, 1'b0);
      send({256'h0, 256'h0102030405060708_090A0B0C0D0E0F10_1112131415161718_191A1B1C1D1E1F20},
           64'h0000_00FF, 1'b1, 1'b0);
      expect_beat("short256_b0", {256'h0, 128'hCAFEBABE_00000000_11111111_22222222,
                  128'h33330000_00000000_00000038_4A00000E}, 64'hFFFF_FFFF, 1'b0, 3'b000);
      expect_beat("short256_b1",
                  {256'h0, 256'h0102030405060708_090A0B0C0D0E0F10_1112131415161718_191A1B1C1D1E1F20},
                  64'h0000_00FF, 1'b1, 3'b100);
      expect_empty("short256_count");
`ifdef LITEPCIE_RC_ERR_CNT_EN
      chk("errcnt256", 512'(cnt256), 512'd1);
`endif

      // 128-bit dwlen=8 CplD over 3 beats with downstream ready toggling
      sel = 2'd2;
      tog = 1'b1;
      send(512'(128'hAAAA0001_00000011_00000008_00200000), 64'hF000, 1'b0, 1'b0);
      send(512'(128'h11112222_33334444_55556666_77778888), 64'hFFFF, 1'b0, 1'b0);
      send(512'(128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000), 64'h0FFF, 1'b1, 1'b0);
      expect_beat("tog128_b0", 512'(128'hAAAA0001_00001100_00000020_4A000008),
                  64'hFFFF, 1'b0, 3'b000);
      expect_beat("tog128_b1", 512'(128'h11112222_33334444_55556666_77778888),
                  64'hFFFF, 1'b0, 3'b000);
      expect_beat("tog128_b2", 512'(128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000),
                  64'h0FFF, 1'b1, 3'b000);
      expect_empty("tog128_count");
      tog = 1'b0;
      sync();

      // Poisoned 3-beat packet, then a clean single-beat packet
      send(512'(128'h00000000_00000000_00004008_00200000), 64'hF000, 1'b0, 1'b0);
      send(512'(128'hA1), 64'hFFFF, 1'b0, 1'b0);
      send(512'(128'hA2), 64'h0FFF, 1'b1, 1'b0);
      send(512'(P1_IN), 64'hF000, 1'b1, 1'b0);
      expect_beat("poison_b0", 512'(128'h00000000_00000000_00000020_4A000008),
                  64'hFFFF, 1'b0, 3'b010);
      expect_beat("poison_b1", 512'(128'hA1), 64'hFFFF, 1'b0, 3'b010);
      expect_beat("poison_b2", 512'(128'hA2), 64'h0FFF, 1'b1, 3'b010);
      expect_beat("poison_next", 512'(P1_OUT), 64'hFFFF, 1'b1, 3'b000);
      expect_empty("poison_count");

      // Discontinue on beat 2 of 4 (dwlen=12), sticky to tlast, cleared for next packet
`ifdef LITEPCIE_RC_ERR_CNT_EN
      cnt_before = cnt128;
`endif
      send(512'(128'h00000000_00000007_0000000C_00300000), 64'hF000, 1'b0, 1'b0);
      send(512'(128'hB1), 64'hFFFF, 1'b0, 1'b1);
      send(512'(128'hB2), 64'hFFFF, 1'b0, 1'b0);
      send(512'(128'hB3), 64'hFFFF, 1'b1, 1'b0);
      send(512'(P1_IN), 64'hF000, 1'b1, 1'b0);
      expect_beat("disc_b0", 512'(128'h00000000_00000700_00000030_4A00000C),
                  64'hFFFF, 1'b0, 3'b000);
      expect_beat("disc_b1", 512'(128'hB1), 64'hFFFF, 1'b0, 3'b001);
      expect_beat("disc_b2", 512'(128'hB2), 64'hFFFF, 1'b0, 3'b001);
      expect_beat("disc_b3", 512'(128'hB3), 64'hFFFF, 1'b1, 3'b001);
      expect_beat("disc_next", 512'(P1_OUT), 64'hFFFF, 1'b1, 3'b000);
      expect_empty("disc_count");
`ifdef LITEPCIE_RC_ERR_CNT_EN
      chk("errcnt128_disc", 512'(cnt128), 512'(cnt_before + 16'd1));
`endif

      // Reset mid-packet, then a fresh packet must be rewritten as SOP
      send(512'(128'h00000000_00000000_00000008_00200000), 64'hF000, 1'b0, 1'b0);
      send(512'(128'hC1C1C1C1), 64'hFFFF, 1'b0, 1'b0);
      rst_n = 1'b0;
      acc_cnt = 0;
      @(negedge clk);
      chk("midrst_tvalid", 512'(ov128), 512'd0);
      chk("midrst_tdata", 512'(d128), 512'd0);
      chk("midrst_tkeep", 512'(k128), 512'd0);
      chk("midrst_tlast", 512'(l128), 512'd0);
      chk("midrst_tuser", 512'(u128), 512'd0);
      sync();
      rst_n = 1'b1;
      sync();
      send(512'(P1_IN), 64'hF000, 1'b1, 1'b0);
      expect_beat("postrst_sop", 512'(P1_OUT), 64'hFFFF, 1'b1, 3'b000);
      expect_empty("postrst_count");

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion expected $finish before 500000");
      $fatal(1, "watchdog");
   end

endmodule
